// File: rtl/bka_pkg.sv
// Shared widths and payload types for the Brent-Kung adder/subtractor family.
package bka_pkg;

    localparam int unsigned BKA_W    = 16;
    localparam int unsigned BKA_LVLS = 4;

    // Mid-tree snapshot: raw propagate plus group G/P after upsweep level 2.
    // gg[0] is the bit-0 carry c0 (carry-in folded in); gg[1]/gg[3] are final carries.
    typedef struct packed {
        logic [BKA_W-1:0] p;
        logic [BKA_W-1:0] gg;
        logic [BKA_W-1:0] pp;
        logic             a_msb;
        logic             b_msb;
    } bka_pg_t;

    // Result word with compare flags.
    typedef struct packed {
        logic [BKA_W-1:0] q;
        logic             borrow;
        logic             zero;
        logic             lt_s;
        logic             ovf;
    } bka_res_t;

endpackage

// File: rtl/bka_pipe_stage.sv
// One valid/ready register slice; accepts when empty or draining this cycle.
module bka_pipe_stage #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready_c,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);
    logic          valid_q;
    logic [DW-1:0] data_q;

    assign in_ready_c = ~valid_q | out_ready;
    assign out_valid  = valid_q;
    assign out_data   = data_q;

    // Slot register: refill or empty when advancing, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready_c) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end
endmodule

// File: rtl/pg_blackcell.sv
// Prefix black cell: combines high and low group (G,P).
module pg_blackcell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g,
    output logic p
);
    assign g = g_hi | (p_hi & g_lo);
    assign p = p_hi & p_lo;
endmodule

// File: rtl/pg_graycell.sv
// Prefix gray cell: group generate only, used where the low side is a carry.
module pg_graycell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    output logic g
);
    assign g = g_hi | (p_hi & g_lo);
endmodule

// File: rtl/pg_onebit.sv
// Per-bit propagate/generate cell.
module pg_onebit (
    input  logic a,
    input  logic b,
    output logic p,
    output logic g
);
    assign p = a ^ b;
    assign g = a & b;
endmodule

// File: rtl/bka16_sub_pipe.sv
// 16-bit pipelined subtractor q = a + ~b + 1 on a Brent-Kung tree, with compare flags.
module bka16_sub_pipe
    import bka_pkg::*;
#(
    parameter int unsigned W        = BKA_W,
    parameter int unsigned PIPE_MID = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] q,
    output logic         borrow,
    output logic         zero,
    output logic         lt_s,
    output logic         ovf
);
    localparam int unsigned PGW = $bits(bka_pg_t);
    localparam int unsigned RW  = $bits(bka_res_t);

    // The tree wiring below is hand-built for exactly 16 bits / 4 levels.
    if (W != BKA_W || (32'd1 << BKA_LVLS) != 32'(BKA_W)) begin : g_bad_width
        $error("bka16_sub_pipe: W must be 16");
    end

    // ---------------- stage 1: pg generation, upsweep levels 1-2 ----------------
    logic [W-1:0] nb;
    logic [W-1:0] bp;
    logic [W-1:0] bg;
    logic [W-1:0] l1_g;
    logic [W-1:0] l1_p;
    logic [W-1:0] l2_g;
    logic [W-1:0] l2_p;
    logic         c0;
    bka_pg_t      pg_c;

    assign nb = ~b;

    for (genvar i = 0; i < W; i++) begin : g_bit
        pg_onebit u_bit (.a(a[i]), .b(nb[i]), .p(bp[i]), .g(bg[i]));
    end

    // Carry-in of 1 folded into bit 0.
    pg_graycell u_cin (.g_hi(bg[0]), .p_hi(bp[0]), .g_lo(1'b1), .g(c0));

    // Upsweep level 1: span 2 at odd positions; position 1 resolves to carry c1.
    for (genvar i = 0; i < W; i++) begin : g_l1
        if (i == 0) begin : g_c0
            assign l1_g[i] = c0;
            assign l1_p[i] = bp[i];
        end else if (i == 1) begin : g_c1
            pg_graycell u_gc (.g_hi(bg[i]), .p_hi(bp[i]), .g_lo(c0), .g(l1_g[i]));
            assign l1_p[i] = bp[i];
        end else if (i % 2 == 1) begin : g_bc
            pg_blackcell u_bc (.g_hi(bg[i]), .p_hi(bp[i]), .g_lo(bg[i-1]), .p_lo(bp[i-1]),
                               .g(l1_g[i]), .p(l1_p[i]));
        end else begin : g_pass
            assign l1_g[i] = bg[i];
            assign l1_p[i] = bp[i];
        end
    end

    // Upsweep level 2: span 4 at positions 3,7,11,15; position 3 resolves to carry c3.
    for (genvar i = 0; i < W; i++) begin : g_l2
        if (i == 3) begin : g_c3
            pg_graycell u_gc (.g_hi(l1_g[i]), .p_hi(l1_p[i]), .g_lo(l1_g[i-2]), .g(l2_g[i]));
            assign l2_p[i] = l1_p[i];
        end else if (i % 4 == 3) begin : g_bc
            pg_blackcell u_bc (.g_hi(l1_g[i]), .p_hi(l1_p[i]), .g_lo(l1_g[i-2]),
                               .p_lo(l1_p[i-2]), .g(l2_g[i]), .p(l2_p[i]));
        end else begin : g_pass
            assign l2_g[i] = l1_g[i];
            assign l2_p[i] = l1_p[i];
        end
    end

    assign pg_c = '{p: bp, gg: l2_g, pp: l2_p, a_msb: a[W-1], b_msb: b[W-1]};

    // ---------------- mid-tree register (optional) ----------------
    logic    s1_in_ready;
    logic    s1_valid;
    bka_pg_t s1_pg;
    logic    s2_in_ready;

    if (PIPE_MID != 0) begin : g_mid
        bka_pipe_stage #(.DW(PGW)) u_s1 (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid),
            .in_ready_c (s1_in_ready),
            .in_data    (pg_c),
            .out_valid  (s1_valid),
            .out_ready  (s2_in_ready),
            .out_data   (s1_pg)
        );
    end else begin : g_no_mid
        assign s1_in_ready = s2_in_ready;
        assign s1_valid    = in_valid;
        assign s1_pg       = pg_c;
    end

    assign in_ready = s1_in_ready;

    // ---------------- stage 2: upsweep levels 3-4, downsweep, sum, flags ----------------
    logic [W-1:0] gg;
    logic [W-1:0] pp;
    logic         c1, c3, c5, c7, c9, c11, c13, c15;
    logic         g15_8, p15_8;
    logic [7:0]   c_odd;
    logic [7:1]   c_even;
    logic [W-1:0] carry;
    logic [W-1:0] sum;
    logic         ovf_c;
    logic         unused_pp;
    bka_res_t     res_c;
    bka_res_t     res_q;

    assign gg = s1_pg.gg;
    assign pp = s1_pg.pp;
    assign c1 = gg[1];
    assign c3 = gg[3];

    // Group P of spans ending at bits 0, 1 and 3 is never needed past level 2.
    assign unused_pp = ^{pp[3], pp[1:0]};

    // Level 3 (span 8) and level 4 (span 16); both land on carries.
    pg_graycell  u_c7   (.g_hi(gg[7]), .p_hi(pp[7]), .g_lo(gg[3]), .g(c7));
    pg_blackcell u_u15  (.g_hi(gg[15]), .p_hi(pp[15]), .g_lo(gg[11]), .p_lo(pp[11]),
                         .g(g15_8), .p(p15_8));
    pg_graycell  u_c15  (.g_hi(g15_8), .p_hi(p15_8), .g_lo(c7), .g(c15));

    // Downsweep: 11, then 5/9/13, then every even position.
    pg_graycell  u_c11  (.g_hi(gg[11]), .p_hi(pp[11]), .g_lo(c7),  .g(c11));
    pg_graycell  u_c5   (.g_hi(gg[5]),  .p_hi(pp[5]),  .g_lo(c3),  .g(c5));
    pg_graycell  u_c9   (.g_hi(gg[9]),  .p_hi(pp[9]),  .g_lo(c7),  .g(c9));
    pg_graycell  u_c13  (.g_hi(gg[13]), .p_hi(pp[13]), .g_lo(c11), .g(c13));

    assign c_odd = {c15, c13, c11, c9, c7, c5, c3, c1};

    for (genvar k = 1; k < 8; k++) begin : g_even
        pg_graycell u_ce (.g_hi(gg[2*k]), .p_hi(pp[2*k]), .g_lo(c_odd[k-1]), .g(c_even[k]));
    end

    // carry[i] is the carry out of bit i.
    for (genvar k = 0; k < 8; k++) begin : g_carry
        assign carry[2*k+1] = c_odd[k];
        if (k == 0) begin : g_b0
            assign carry[0] = gg[0];
        end else begin : g_bk
            assign carry[2*k] = c_even[k];
        end
    end

    assign sum   = s1_pg.p ^ {carry[W-2:0], 1'b1};
    assign ovf_c = (s1_pg.a_msb ^ s1_pg.b_msb) & (sum[W-1] ^ s1_pg.a_msb);
    assign res_c = '{q: sum, borrow: ~carry[W-1], zero: ~|sum,
                     lt_s: sum[W-1] ^ ovf_c, ovf: ovf_c};

    // Output register slice.
    bka_pipe_stage #(.DW(RW)) u_s2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (s1_valid),
        .in_ready_c (s2_in_ready),
        .in_data    (res_c),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (res_q)
    );

    assign q      = res_q.q;
    assign borrow = res_q.borrow;
    assign zero   = res_q.zero;
    assign lt_s   = res_q.lt_s;
    assign ovf    = res_q.ovf;

endmodule

// File: tb/tb_bka16_sub_pipe.sv
// Self-checking bench for bka16_sub_pipe (both mid-register settings).
module tb_bka16_sub_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_valid0;
    logic        out_ready;
    logic [15:0] a;
    logic [15:0] b;

    logic        in_ready, out_valid, borrow, zero, lt_s, ovf;
    logic [15:0] q;
    logic        in_ready0, out_valid0, borrow0, zero0, lt_s0, ovf0;
    logic [15:0] q0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [19:0] exp_q[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [19:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    bka16_sub_pipe #(.W(16), .PIPE_MID(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .borrow(borrow), .zero(zero), .lt_s(lt_s), .ovf(ovf)
    );

    bka16_sub_pipe #(.W(16), .PIPE_MID(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
        .q(q0), .borrow(borrow0), .zero(zero0), .lt_s(lt_s0), .ovf(ovf0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain modular / signed integer arithmetic.
    function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y);
        int sx, sy, sd;
        logic [19:0] r;
        sx = int'($signed(x));
        sy = int'($signed(y));
        sd = sx - sy;
        r[19:4] = x - y;
        r[3]    = (x < y);
        r[2]    = (x == y);
        r[1]    = (sx < sy);
        r[0]    = (sd > 32767) || (sd < -32768);
        return r;
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every visible result must match the oldest accepted operand pair.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_out: out_valid=1 q=%h, expected no result", q);
                end else begin
                    check("sb_result", 32'({q, borrow, zero, lt_s, ovf}), 32'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vec[12];
        logic [15:0] sa[8];
        logic [15:0] sb[8];
        int          lat, idx, sent, cyc;
        logic        fire;

        vec[0]  = '{16'h1234, 16'h0234, {16'h1000, 4'b0000}};
        vec[1]  = '{16'h0000, 16'h0001, {16'hFFFF, 4'b1010}};
        vec[2]  = '{16'hA5A5, 16'hA5A5, {16'h0000, 4'b0100}};
        vec[3]  = '{16'h8000, 16'h0001, {16'h7FFF, 4'b0011}};
        vec[4]  = '{16'h7FFF, 16'hFFFF, {16'h8000, 4'b1001}};
        vec[5]  = '{16'hFFFF, 16'h0000, {16'hFFFF, 4'b0010}};
        vec[6]  = '{16'h0001, 16'hFFFF, {16'h0002, 4'b1000}};
        vec[7]  = '{16'h0000, 16'h8000, {16'h8000, 4'b1001}};
        vec[8]  = '{16'h5555, 16'hAAAA, {16'hAAAB, 4'b1001}};
        vec[9]  = '{16'h1000, 16'h0001, {16'h0FFF, 4'b0000}};
        vec[10] = '{16'h8001, 16'h7FFF, {16'h0002, 4'b0011}};
        vec[11] = '{16'hFFFF, 16'hFFFF, {16'h0000, 4'b0100}};

        // Reset held three cycles.
        rst_n = 1'b0; in_valid = 1'b0; in_valid0 = 1'b0; out_ready = 1'b1;
        a = '0; b = '0;
        repeat (3) step();
        check("reset_out_valid", 32'(out_valid), 32'(0));
        check("reset_result", 32'({q, borrow, zero, lt_s, ovf}), 32'(0));
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'(1));

        // Directed table: both pipe depths, latency and values.
        for (int i = 0; i < 12; i++) begin
            a = vec[i].a; b = vec[i].b; in_valid = 1'b1; in_valid0 = 1'b1;
            #1;
            check("tbl_in_ready0", 32'(in_ready0), 32'(1));
            step();
            in_valid = 1'b0; in_valid0 = 1'b0;
            check("tbl_nomid_lat1", 32'({out_valid0, q0, borrow0, zero0, lt_s0, ovf0}),
                  32'({1'b1, vec[i].exp}));
            lat = 1;
            while (!out_valid && lat < 6) begin
                step();
                lat++;
            end
            check("tbl_latency", 32'(lat), 32'(2));
            check("tbl_result", 32'({q, borrow, zero, lt_s, ovf}), 32'(vec[i].exp));
            step();
        end

        // 8 back-to-back ops with out_ready low for cycles 3..6.
        for (int i = 0; i < 8; i++) begin
            sa[i] = 16'($urandom);
            sb[i] = 16'($urandom);
        end
        idx = 0;
        for (int k = 0; k < 40 && idx < 8; k++) begin
            out_ready = !(k >= 3 && k <= 6);
            in_valid = 1'b1; a = sa[idx]; b = sb[idx];
            #1;
            if (k >= 3 && k <= 6) check("stall_in_ready", 32'(in_ready), 32'(0));
            if (k == 7) check("unstall_in_ready", 32'(in_ready), 32'(1));
            fire = in_ready;
            step();
            if (fire) idx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream_sent", 32'(idx), 32'(8));
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
        check("stream_drained", 32'(exp_q.size()), 32'(0));

        // Reset with two ops in flight.
        out_ready = 1'b1; in_valid = 1'b1; a = 16'h4321; b = 16'h0021;
        step();
        a = 16'h0F0F; b = 16'h0101;
        step();
        in_valid = 1'b0;
        check("pre_reset_valid", 32'(out_valid), 32'(1));
        rst_n = 1'b0;
        #1;
        check("reset_kills_valid", 32'(out_valid), 32'(0));
        step(); step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("no_stale_after_reset", 32'(out_valid), 32'(0));
        end

        // Random traffic with random valid/ready; source holds while stalled.
        sent = 0; cyc = 0; in_valid = 1'b0;
        while (sent < 3000 && cyc < 20000) begin
            if (!in_valid) begin
                in_valid = ($urandom_range(0, 9) < 7);
                a = pick();
                b = pick();
            end
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            fire = in_valid && in_ready;
            step();
            cyc++;
            if (fire) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        check("random_sent", 32'(sent), 32'(3000));
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
        check("random_drained", 32'(exp_q.size()), 32'(0));
        step();
        check("idle_out_valid", 32'(out_valid), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
